// File: rtl/linebuffer_3x3_stream_pkg.sv
// Shared definitions for the 3x3 line-buffer window generator:
// FSM state encoding, window element indices and a lane offset helper.
package linebuffer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Window element order inside one lane: row-major, top-left first,
    // bottom-right (the pixel just accepted) last.
    localparam int K_TL = 0;
    localparam int K_TM = 1;
    localparam int K_TR = 2;
    localparam int K_ML = 3;
    localparam int K_MM = 4;
    localparam int K_MR = 5;
    localparam int K_BL = 6;
    localparam int K_BM = 7;
    localparam int K_BR = 8;
    localparam int WIN_ELEMS = 9;

    // Bit offset of lane `lane` in a bus made of lanes `dw` bits wide.
    function automatic int lane_off(input int lane, input int dw);
        return lane * dw;
    endfunction

endpackage

// File: rtl/linebuffer_3x3_stream_if.sv
// Bus bundle of the 3x3 window generator: frame control, pixel input
// stream, window output stream and status.
//
// Handshake: both streams use valid/ready. A transfer happens on a rising
// clock edge where valid and ready are both high. A source holds valid and
// its payload stable until that transfer; ready may change at any time and
// never depends combinationally on the source's own valid.
interface linebuffer_3x3_stream_if #(
    parameter int CH = 8,
    parameter int DW = 8,
    parameter int WW = 9
);
    logic                   start;
    logic [WW-1:0]          cfg_width;
    logic [WW-1:0]          cfg_height;
    logic                   in_valid;
    logic                   in_ready;
    logic [CH*DW-1:0]       in_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [CH*9*DW-1:0]     out_win;
    logic                   out_last;
    logic                   busy;
    logic                   frame_done;
    linebuffer_pkg::state_t dbg_state;

    // Upstream/downstream environment side.
    modport master (
        output start, cfg_width, cfg_height, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_win, out_last, busy, frame_done, dbg_state
    );

    // Window generator side.
    modport slave (
        input  start, cfg_width, cfg_height, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_win, out_last, busy, frame_done, dbg_state
    );
endinterface

// File: rtl/linebuffer_3x3_stream_row_ram.sv
// Two line stores (previous row and the row before it). Asynchronous read
// at the current column; on an accepted pixel the column shifts one row up:
// older row takes the newer row's value, newer row takes the incoming pixel.
// Contents are not reset: every column is rewritten before it is read for a
// window.
module linebuffer_row_ram #(
    parameter int LW    = 64,
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [LW-1:0] i_din,
    output logic [LW-1:0] o_lb0,
    output logic [LW-1:0] o_lb1
);
    logic [LW-1:0] r_lb0 [DEPTH];
    logic [LW-1:0] r_lb1 [DEPTH];

    assign o_lb0 = r_lb0[i_addr];
    assign o_lb1 = r_lb1[i_addr];

    // Shift the addressed column up by one row on each accepted pixel.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_lb1[i_addr] <= r_lb0[i_addr];
            r_lb0[i_addr] <= i_din;
        end
    end
endmodule

// File: rtl/linebuffer_3x3_stream.sv
// 3x3 sliding-window generator for CH parallel lanes over a row-major,
// already zero-padded pixel stream with runtime width/height.
// Optional build macro LINEBUF_STRIDE2_EN: emit windows at stride 2 only.
module linebuffer_3x3_stream
    import linebuffer_pkg::*;
#(
    parameter int CH    = 8,
    parameter int DW    = 8,
    parameter int MAX_W = 256,
    parameter int WW    = 9
) (
    input logic                    clk,
    input logic                    rst,
    linebuffer_3x3_stream_if.slave bus
);
    localparam int LW = CH * DW;
    localparam int OW = CH * WIN_ELEMS * DW;
    localparam int AW = (MAX_W > 1) ? $clog2(MAX_W) : 1;
    localparam logic [WW-1:0] L_ONE = WW'(1);
    localparam logic [WW-1:0] L_TWO = WW'(2);
    localparam logic [WW-1:0] L_MIN = WW'(3);
    localparam logic [WW-1:0] L_MAX = WW'(MAX_W);

    state_t              r_state, w_next_state;
    logic [WW-1:0]       r_width, r_height, r_row, r_col;
    logic [2:0][LW-1:0]  r_c1, r_c2, w_c_new;   // [0]=top, [1]=mid, [2]=bottom
    logic [LW-1:0]       w_lb0, w_lb1;
    logic                r_out_valid, r_out_last;
    logic [OW-1:0]       r_out_win, w_win;
    logic                w_in_ready, w_accept, w_cfg_ok;
    logic                w_col_end, w_row_end, w_emit, w_last_win;

    assign w_cfg_ok  = (bus.cfg_width >= L_MIN) && (bus.cfg_width <= L_MAX) &&
                       (bus.cfg_height >= L_MIN);
    assign w_accept  = bus.in_valid && w_in_ready;
    assign w_col_end = (r_col == r_width - L_ONE);
    assign w_row_end = (r_row == r_height - L_ONE);

`ifdef LINEBUF_STRIDE2_EN
    logic [WW-1:0] w_last_row, w_last_col;
    // Last emitted position is the last even offset from 2 in each axis.
    assign w_last_row = r_height[0] ? (r_height - L_ONE) : (r_height - L_TWO);
    assign w_last_col = r_width[0]  ? (r_width - L_ONE)  : (r_width - L_TWO);
    assign w_emit     = (r_row >= L_TWO) && (r_col >= L_TWO) && !r_row[0] && !r_col[0];
    assign w_last_win = (r_row == w_last_row) && (r_col == w_last_col);
`else
    assign w_emit     = (r_row >= L_TWO) && (r_col >= L_TWO);
    assign w_last_win = w_row_end && w_col_end;
`endif

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next_state;
    end

    // FSM next state: bad configs skip straight to DONE.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (bus.start) w_next_state = w_cfg_ok ? ST_RUN : ST_DONE;
            ST_RUN:  if (w_accept && w_col_end && w_row_end) w_next_state = ST_DONE;
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // FSM outputs: accept only while RUN and the output slot can take a window.
    always_comb begin
        w_in_ready     = (r_state == ST_RUN) && (!r_out_valid || bus.out_ready);
        bus.in_ready   = w_in_ready;
        bus.busy       = (r_state != ST_IDLE);
        bus.frame_done = (r_state == ST_DONE);
        bus.dbg_state  = r_state;
    end

    // Config latch and row/column position of the next pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_width  <= '0;
            r_height <= '0;
            r_row    <= '0;
            r_col    <= '0;
        end else if (r_state == ST_IDLE && bus.start) begin
            r_width  <= bus.cfg_width;
            r_height <= bus.cfg_height;
            r_row    <= '0;
            r_col    <= '0;
        end else if (w_accept) begin
            if (w_col_end) begin
                r_col <= '0;
                r_row <= r_row + L_ONE;
            end else begin
                r_col <= r_col + L_ONE;
            end
        end
    end

    linebuffer_row_ram #(.LW(LW), .DEPTH(MAX_W), .AW(AW)) u_row_ram (
        .clk    (clk),
        .i_we   (w_accept),
        .i_addr (r_col[AW-1:0]),
        .i_din  (bus.in_data),
        .o_lb0  (w_lb0),
        .o_lb1  (w_lb1)
    );

    assign w_c_new[0] = w_lb1;
    assign w_c_new[1] = w_lb0;
    assign w_c_new[2] = bus.in_data;

    // Window columns shift left on every accepted pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_c1 <= '0;
            r_c2 <= '0;
        end else if (w_accept) begin
            r_c1 <= r_c2;
            r_c2 <= w_c_new;
        end
    end

    // Window as it stands after this pixel: two stored columns plus the new one.
    for (genvar n = 0; n < CH; n++) begin : g_lane
        for (genvar k = 0; k < WIN_ELEMS; k++) begin : g_elem
            if (k % 3 == 0) begin : g_left
                assign w_win[lane_off(n, WIN_ELEMS*DW) + k*DW +: DW] = r_c1[k/3][lane_off(n, DW) +: DW];
            end else if (k % 3 == 1) begin : g_mid
                assign w_win[lane_off(n, WIN_ELEMS*DW) + k*DW +: DW] = r_c2[k/3][lane_off(n, DW) +: DW];
            end else begin : g_right
                assign w_win[lane_off(n, WIN_ELEMS*DW) + k*DW +: DW] = w_c_new[k/3][lane_off(n, DW) +: DW];
            end
        end
    end

    // Output slot: load on an emitting accept, empty when the consumer takes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_win   <= '0;
        end else if (w_accept && w_emit) begin
            r_out_valid <= 1'b1;
            r_out_last  <= w_last_win;
            r_out_win   <= w_win;
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_last  = r_out_last;
    assign bus.out_win   = r_out_win;
endmodule
